// File: rtl/ysyx_22040237_mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_22040237_mem_arb_pkg : shared widths, arbiter state and owner encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package ysyx_22040237_mem_arb_pkg;

  localparam int REG_WIDTH  = 64;
  localparam int INST_WIDTH = 32;

  localparam int ARB_ADDR_W = REG_WIDTH;
  localparam int ARB_DATA_W = REG_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  // The LSU takes priority unless the IFU has been starved long enough.
  function automatic logic arb_ifu_wins(input logic if_v, input logic ls_v,
                                        input logic starved);
    return if_v && (starved || !ls_v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040237_mem_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_22040237_mem_arb : single-outstanding IFU/LSU arbiter for the memory
// Rev 1.0
// ----------------------------------------------------------------------------
module ysyx_22040237_mem_arb
  import ysyx_22040237_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_resp_valid,

  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  output logic                  ls_resp_valid,

  output logic [DATA_W-1:0]     resp_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e          state_q,  state_d;
  arb_owner_e          owner_q,  owner_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic                wen_q,    wen_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [MASK_W-1:0]   wmask_q,  wmask_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;

  logic grant_if;
  logic grant_ls;

  // Grants are gated by reset so the ready outputs drop as soon as rst falls.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (rst && (state_q == ST_IDLE)) begin
      if (arb_ifu_wins(if_req_valid, ls_req_valid, starve_q == CNT_MAX)) begin
        grant_if = 1'b1;
      end else if (ls_req_valid) begin
        grant_ls = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          starve_d = '0;
          state_d  = ST_REQ;
        end else if (grant_ls) begin
          owner_d = OWN_LS;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
          if (if_req_valid && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
          end
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          // A memory that answers in the handshake cycle skips WAIT entirely.
          if (mem_resp_valid) begin
            rdata_d = mem_rdata;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
    end
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign if_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign ls_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LS);
  assign resp_rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040237_mem_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ysyx_22040237_mem_arb : scoreboard bench for the IFU/LSU memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ysyx_22040237_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr;
  logic        ls_req_valid, ls_req_ready, ls_resp_valid, ls_wen;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic [63:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_22040237_mem_arb #(
    .ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_resp_valid(if_resp_valid),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_resp_valid(ls_resp_valid),
    .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        is_if;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } txn_t;

  txn_t sb_q[$];
  txn_t mem_q[$];
  byte  grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_ready_dly = 0;
  int   mem_resp_dly  = 1;
  txn_t gm_t, rm_t, mm_t;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant monitor: records each accepted request into the scoreboard queues.
  always @(negedge clk) begin
    if (rst && (if_req_ready || ls_req_ready)) begin
      check("single_grant", {63'd0, if_req_ready && ls_req_ready}, 64'd0);
      if (if_req_ready) begin
        check("if_ready_needs_valid", {63'd0, if_req_valid}, 64'd1);
        gm_t.is_if = 1'b1; gm_t.wen = 1'b0; gm_t.addr = if_addr;
        gm_t.wdata = 64'd0; gm_t.wmask = 8'd0;
        grant_log.push_back("I");
      end else begin
        check("ls_ready_needs_valid", {63'd0, ls_req_valid}, 64'd1);
        gm_t.is_if = 1'b0; gm_t.wen = ls_wen; gm_t.addr = ls_addr;
        gm_t.wdata = ls_wdata; gm_t.wmask = ls_wmask;
        grant_log.push_back("L");
      end
      sb_q.push_back(gm_t);
      mem_q.push_back(gm_t);
    end
  end

  // Response monitor: pops the oldest accepted request on every response pulse.
  always @(negedge clk) begin
    if (rst && (if_resp_valid || ls_resp_valid)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: if_resp_valid=%0b ls_resp_valid=%0b, expected no response",
                 if_resp_valid, ls_resp_valid);
      end else begin
        rm_t = sb_q.pop_front();
        check("resp_owner_if", {63'd0, if_resp_valid}, {63'd0, rm_t.is_if});
        check("resp_owner_ls", {63'd0, ls_resp_valid}, {63'd0, !rm_t.is_if});
        if (!rm_t.wen) check("resp_rdata", resp_rdata, mem_word(rm_t.addr));
      end
    end
  end

  // Memory model with programmable ready and response delays; checks payload stability.
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      if (rst && mem_req_valid) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected_req: got mem_req_valid=1 expected no request");
          mm_t.is_if = 1'b0; mm_t.wen = 1'b0; mm_t.addr = 64'd0;
          mm_t.wdata = 64'd0; mm_t.wmask = 8'd0;
        end else begin
          mm_t = mem_q.pop_front();
        end
        for (int i = 0; i <= mem_ready_dly; i++) begin
          if (i > 0) begin @(posedge clk); #1; end
          check("mem_req_valid_held", {63'd0, mem_req_valid}, 64'd1);
          check("mem_addr", mem_addr, mm_t.addr);
          check("mem_wen", {63'd0, mem_wen}, {63'd0, mm_t.wen});
          if (mm_t.wen) begin
            check("mem_wdata", mem_wdata, mm_t.wdata);
            check("mem_wmask", {56'd0, mem_wmask}, {56'd0, mm_t.wmask});
          end
        end
        mem_req_ready = 1'b1;
        if (mem_resp_dly == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata = mm_t.wen ? 64'hFFFF_FFFF_FFFF_FFFF : mem_word(mm_t.addr);
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'd0;
        if (mem_resp_dly > 0) begin
          for (int i = 1; i < mem_resp_dly; i++) begin @(posedge clk); #1; end
          mem_resp_valid = 1'b1;
          mem_rdata = mm_t.wen ? 64'hFFFF_FFFF_FFFF_FFFF : mem_word(mm_t.addr);
          @(posedge clk); #1;
          mem_resp_valid = 1'b0; mem_rdata = 64'd0;
        end
      end
    end
  end

  task automatic if_send(input logic [63:0] a);
    bit got = 1'b0;
    if_req_valid = 1'b1; if_addr = a;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (if_req_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    check("if_grant", {63'd0, got}, 64'd1);
  endtask

  task automatic ls_send(input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] m);
    bit got = 1'b0;
    ls_req_valid = 1'b1; ls_addr = a; ls_wen = w; ls_wdata = d; ls_wmask = m;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ls_req_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    check("ls_grant", {63'd0, got}, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string exp);
    check("grant_count", 64'(grant_log.size()), 64'(exp.len()));
    for (int i = 0; i < exp.len() && i < grant_log.size(); i++) begin
      check("grant_order", {56'd0, grant_log[i]}, {56'd0, exp[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    bit  flag;
    rst = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_1000; ls_wen = 1'b1;
    ls_wdata = 64'hA5A5_A5A5_A5A5_A5A5; ls_wmask = 8'hFF;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
    check("rst_ls_ready", {63'd0, ls_req_ready}, 64'd0);
    check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_resp_valid", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_payload", {mem_wdata[55:0], mem_wmask}, 64'd0);
    if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_wen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // IFU-only read at 0x80000000: ready at 0, resp at cycle 3
    grant_log.delete();
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    @(negedge clk);
    check("t1_if_ready_c0", {63'd0, if_req_ready}, 64'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    check("t1_mem_req_valid_c1", {63'd0, mem_req_valid}, 64'd1);
    @(negedge clk);
    check("t1_if_resp_c2", {63'd0, if_resp_valid}, 64'd0);
    @(negedge clk);
    check("t1_if_resp_c3", {63'd0, if_resp_valid}, 64'd1);
    check("t1_rdata_c3", resp_rdata, 64'h5EAD_BEEF_8000_0000);
    drain();

    // Simultaneous IFU and LSU: LSU wins, IFU served after ls_resp_valid
    grant_log.delete();
    fork
      ls_send(64'h8000_1000, 1'b0, 64'd0, 8'd0);
      if_send(64'h8000_0004);
      begin
        @(negedge clk);
        check("t2_ls_ready", {63'd0, ls_req_ready}, 64'd1);
        check("t2_if_ready", {63'd0, if_req_ready}, 64'd0);
        flag = 1'b0; seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
          @(negedge clk);
          if (ls_resp_valid) seen = 1;
          else if (if_req_ready) flag = 1'b1;
        end
        check("t2_ls_resp_seen", 64'(seen), 64'd1);
        check("t2_if_held_off", {63'd0, flag}, 64'd0);
      end
    join
    drain();
    check_log("LI");

    // Ready and response in the same cycle: REQ goes straight to RESP
    mem_resp_dly = 0;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_2008; ls_wen = 1'b0;
    @(negedge clk);
    check("t3_ls_ready_c0", {63'd0, ls_req_ready}, 64'd1);
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    @(negedge clk);
    check("t3_mem_req_valid_c1", {63'd0, mem_req_valid}, 64'd1);
    check("t3_ls_resp_c1", {63'd0, ls_resp_valid}, 64'd0);
    @(negedge clk);
    check("t3_ls_resp_c2", {63'd0, ls_resp_valid}, 64'd1);
    drain();
    mem_resp_dly = 1;

    // LSU write, mask 0x0F, memory ready delayed by 3 cycles
    mem_ready_dly = 3;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_3000; ls_wen = 1'b1;
    ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'h0F;
    @(negedge clk);
    check("t4_ls_ready", {63'd0, ls_req_ready}, 64'd1);
    @(posedge clk); #1;
    ls_req_valid = 1'b0; ls_wen = 1'b0;
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      @(negedge clk);
      if (mem_resp_valid) seen = 1;
    end
    check("t4_mem_resp_seen", 64'(seen), 64'd1);
    check("t4_ls_resp_early", {63'd0, ls_resp_valid}, 64'd0);
    @(negedge clk);
    check("t4_ls_resp_next", {63'd0, ls_resp_valid}, 64'd1);
    drain();
    mem_ready_dly = 0;

    // Reset during WAIT: transaction dropped, stray response ignored
    mem_resp_dly = 6;
    ls_send(64'h8000_0200, 1'b0, 64'd0, 8'd0);
    @(posedge clk); #1;
    check("t5_in_wait", {63'd0, mem_req_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ls_req_valid = 1'b1; if_req_valid = 1'b1;
    #1;
    check("t5_rst_ls_ready", {63'd0, ls_req_ready}, 64'd0);
    check("t5_rst_if_ready", {63'd0, if_req_ready}, 64'd0);
    check("t5_rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("t5_rst_resp_valid", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    check("t5_rst_rdata", resp_rdata, 64'd0);
    check("t5_rst_mem_addr", mem_addr, 64'd0);
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    sb_q.delete();
    mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_resp_valid || ls_resp_valid) seen++;
    end
    check("t5_no_stray_resp", 64'(seen), 64'd0);
    @(posedge clk); #1;
    mem_resp_dly = 1;
    ls_send(64'h8000_0208, 1'b0, 64'd0, 8'd0);
    drain();

    // Starvation: 4 LSU grants, then IFU, then the count restarts from 0
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) ls_send(64'h8000_4000 + 64'(i * 8), 1'b0, 64'd0, 8'd0);
      end
      begin
        for (int i = 0; i < 2; i++) if_send(64'h8000_0010 + 64'(i * 4));
      end
    join
    drain();
    check_log("LLLLILLLLI");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22040237_mem_arb.md
YSYX_22040237_MEM_ARB -- requirements
Module: ysyx_22040237_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the width of all address ports.
REQ-002 Parameter DATA_W, default 64, SHALL set the width of all data ports.
REQ-003 Parameter STARVE_MAX, default 4, SHALL be the maximum number of consecutive LSU grants issued while an IFU request is pending.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 if_req_valid  in  1  IFU fetch request.
REQ-007 if_req_ready  out  1  IFU request accepted this cycle.
REQ-008 if_addr  in  ADDR_W  IFU fetch address (pc).
REQ-009 if_resp_valid  out  1  IFU read data valid (one-cycle pulse).
REQ-010 ls_req_valid  in  1  LSU request.
REQ-011 ls_req_ready  out  1  LSU request accepted this cycle.
REQ-012 ls_addr  in  ADDR_W  LSU address.
REQ-013 ls_wen / ls_wdata / ls_wmask  in  1 / DATA_W / DATA_W/8  LSU write enable, write data, byte mask.
REQ-014 ls_resp_valid  out  1  LSU response valid (one-cycle pulse; read data or write ack).
REQ-015 resp_rdata  out  DATA_W  shared response data, qualified by if_resp_valid or ls_resp_valid.
REQ-016 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-017 mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  memory request payload.
REQ-018 mem_resp_valid / mem_rdata  in  1 / DATA_W  memory response.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, WAIT, RESP; at most one transaction outstanding.
REQ-020 IDLE: if any req_valid is high, the winner's req_ready SHALL be 1 combinationally that cycle; addr/wen/wdata/wmask and the owner (IF/LS) SHALL be latched; next state REQ. The loser's req_ready SHALL be 0.
REQ-021 Arbitration: LSU wins by default; IFU wins when the starvation counter equals STARVE_MAX and if_req_valid is high.
REQ-022 Starvation counter SHALL increment on each LSU grant while if_req_valid is high, saturate at STARVE_MAX, and clear on any IFU grant.
REQ-023 REQ: mem_req_valid=1 with latched payload, held stable until mem_req_ready; on mem_req_ready go to WAIT, or directly to RESP if mem_resp_valid is high in the same cycle (rdata captured).
REQ-024 WAIT: on mem_resp_valid, capture mem_rdata into resp_rdata register; next RESP.
REQ-025 RESP: owner's resp_valid SHALL be 1 for exactly one cycle (no backpressure); next IDLE. New arbitration occurs only in IDLE.
REQ-026 Minimum latency: req accepted in cycle N -> mem_req_valid in N+1 -> resp_valid in N+3 when the memory is ready and responds in N+2.
REQ-027 Writes SHALL follow the same sequence; resp_rdata is don't-care on write acks.
REQ-028 mem_resp_valid in IDLE, REQ (without mem_req_ready) or RESP SHALL be ignored.
REQ-029 mem_wen SHALL be 0 for all IFU transactions.

Reset
REQ-030 On rst low: state=IDLE, counter=0, all req_ready, resp_valid and mem_req_valid outputs 0, resp_rdata=0, latched payload=0; any in-flight transaction is dropped without a response.

Structure
REQ-031 State encoding, owner encoding and ADDR_W/DATA_W defaults SHALL live in the shared ysyx_22040237 defines package alongside REG_WIDTH/INST_WIDTH.
REQ-032 No sub-modules; a single FSM plus payload registers. The arbiter SHALL sit between the IFU/LSU and the DPI memory model.

Verification
REQ-033 IFU-only read, addr 0x80000000, memory ready at once, responds next cycle -> if_req_ready at cycle 0, if_resp_valid at cycle 3, resp_rdata = memory word.
REQ-034 IFU and LSU valid simultaneously in IDLE -> ls_req_ready=1, if_req_ready=0; the IFU is served only after ls_resp_valid.
REQ-035 LSU held valid continuously with IFU valid, STARVE_MAX=4 -> exactly 4 LSU grants, then an IFU grant, then the counter is 0.
REQ-036 LSU write wmask 0x0F, mem_req_ready delayed 3 cycles -> payload stable throughout; mem_wen=1; ls_resp_valid one cycle after mem_resp_valid.
REQ-037 rst asserted during WAIT -> outputs zero immediately; after release, stray mem_resp_valid ignored; the next request completes normally.
REQ-038 mem_req_ready and mem_resp_valid in the same cycle -> REQ to RESP directly; the owner's resp_valid fires the next cycle.
